// File: rtl/sync_monitor_pkg.sv
// sync_monitor_pkg: shared FSM state encoding and implementation-select names
package sync_monitor_pkg;
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;
    localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
    localparam string ARCH_VIRTEX5    = "VIRTEX5";
    localparam string ARCH_VIRTEX6    = "VIRTEX6";
endpackage

// File: rtl/sync_phase_counter.sv
// sync_phase_counter: enabled phase counter wrapping at PERIOD-1 with load-to-zero
module sync_phase_counter #(
    parameter int PERIOD = 1024,
    parameter int WIDTH  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_zero,
    output logic [WIDTH-1:0] phase,
    output logic             tc
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
    assign tc = phase == LAST;
    always_ff @(posedge clk or negedge rst)
        if (!rst) phase <= '0;
        else if (en) phase <= (load_zero || tc) ? '0 : phase + 1'b1;
endmodule

// File: rtl/sync_monitor.sv
// sync_monitor: locks onto a periodic sync, flywheels through misses and counts errors
module sync_monitor
    import sync_monitor_pkg::*;
#(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    PERIOD       = 1024,
    parameter int    PHASE_WIDTH  = 10,
    parameter int    LOCK_COUNT   = 3,
    parameter int    MAX_MISS     = 2,
    parameter int    ERR_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   sync_in,
    output logic                   sync_out,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   locked,
    output logic                   err_early,
    output logic                   err_missing,
    output logic [ERR_WIDTH-1:0]   err_count
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_COUNT);
    localparam logic [MW-1:0] MISS_C = MW'(MAX_MISS);
    if (ARCHITECTURE != ARCH_BEHAVIORAL && ARCHITECTURE != ARCH_VIRTEX5 &&
        ARCHITECTURE != ARCH_VIRTEX6) begin : g_bad_arch
        $error("sync_monitor: unsupported ARCHITECTURE");
    end
    state_t state, state_n;
    logic [GW-1:0] good, good_n;
    logic [MW-1:0] miss, miss_n;
    logic tc, load, sync_n, early_n, missing_n;
    logic sync, ontime, early, absent;
    assign sync   = en & sync_in;
    assign ontime = sync & tc;
    assign early  = sync & ~tc;
    assign absent = en & tc & ~sync_in;
    sync_phase_counter #(.PERIOD(PERIOD), .WIDTH(PHASE_WIDTH)) u_phase (
        .clk(clk), .rst(rst), .en(en), .load_zero(load), .phase(phase), .tc(tc)
    );
    always_comb begin
        state_n   = state;
        good_n    = good;
        miss_n    = miss;
        load      = 1'b0;
        sync_n    = 1'b0;
        early_n   = 1'b0;
        missing_n = 1'b0;
        case (state)
            SEARCH: if (sync) begin
                load    = 1'b1;
                good_n  = GW'(1);
                miss_n  = '0;
                state_n = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
                sync_n  = LOCK_COUNT == 1;
            end
            ACQUIRE: begin
                if (ontime) begin
                    good_n = good + 1'b1;
                    if (good + 1'b1 == LOCK_C) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                        sync_n  = 1'b1;
                    end
                end else if (early) begin
                    load   = 1'b1;
                    good_n = GW'(1);
                end else if (absent) state_n = SEARCH;
            end
            LOCKED: begin
                if (ontime) begin
                    miss_n = '0;
                    sync_n = 1'b1;
                end else if (absent) begin
                    // flywheel: the phase still wraps, so the regenerated pulse continues
                    missing_n = 1'b1;
                    sync_n    = 1'b1;
                    miss_n    = miss + 1'b1;
                    if (miss + 1'b1 == MISS_C) state_n = SEARCH;
                end else if (early) begin
                    early_n = 1'b1;
                    load    = 1'b1;
                    good_n  = GW'(1);
                    state_n = ACQUIRE;
                end
            end
            default: state_n = SEARCH;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= SEARCH;
            good        <= '0;
            miss        <= '0;
            sync_out    <= 1'b0;
            locked      <= 1'b0;
            err_early   <= 1'b0;
            err_missing <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            good        <= good_n;
            miss        <= miss_n;
            sync_out    <= sync_n;
            locked      <= state_n == LOCKED;
            err_early   <= early_n;
            err_missing <= missing_n;
            if ((early_n || missing_n) && err_count != '1) err_count <= err_count + 1'b1;
        end
endmodule

// File: tb/tb_sync_monitor.sv
// tb_sync_monitor: directed scenarios for sync_monitor with PERIOD=8, LOCK_COUNT=3, MAX_MISS=2, ERR_WIDTH=2
module tb_sync_monitor;
    logic clk = 1'b0, rst = 1'b0, en = 1'b1, sync_in = 1'b0;
    logic sync_out, locked, err_early, err_missing;
    logic [2:0] phase;
    logic [1:0] err_count;
    int n_cmp = 0, n_err = 0;

    sync_monitor #(.ARCHITECTURE("BEHAVIORAL"), .PERIOD(8), .PHASE_WIDTH(3), .LOCK_COUNT(3),
                   .MAX_MISS(2), .ERR_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sync_in(sync_in), .sync_out(sync_out), .phase(phase),
        .locked(locked), .err_early(err_early), .err_missing(err_missing), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input logic s);
        sync_in = s;
        @(posedge clk);
        #1;
        sync_in = 1'b0;
    endtask

    // seven idle cycles then one cycle carrying s at phase 7
    task automatic period(input logic s);
        for (int i = 0; i < 7; i++) tick(1'b0);
        tick(s);
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if ({sync_out, locked, err_early, err_missing} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b want 0000", {sync_out, locked, err_early, err_missing}); end
        n_cmp++; if (phase !== 3'd0) begin n_err++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_cmp++; if (err_count !== 2'd0) begin n_err++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
        rst = 1'b1;
        tick(1'b0);
        n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL release_phase got %0d want 1", phase); end
    endtask

    task automatic test_lock;
        for (int i = 0; i < 8; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (phase !== 3'd0 || locked !== 1'b0) begin n_err++; $display("FAIL first_sync phase=%0d locked=%b want 0/0", phase, locked); end
        period(1'b1);
        n_cmp++; if (locked !== 1'b0 || sync_out !== 1'b0) begin n_err++; $display("FAIL second_sync locked=%b sync_out=%b want 0/0", locked, sync_out); end
        period(1'b1);
        n_cmp++; if (locked !== 1'b1 || sync_out !== 1'b1) begin n_err++; $display("FAIL lock locked=%b sync_out=%b want 1/1", locked, sync_out); end
        tick(1'b0);
        n_cmp++; if (sync_out !== 1'b0) begin n_err++; $display("FAIL sync_out_width got %b want 0", sync_out); end
        for (int i = 0; i < 6; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (sync_out !== 1'b1 || locked !== 1'b1) begin n_err++; $display("FAIL lock_repeat sync_out=%b locked=%b want 1/1", sync_out, locked); end
        period(1'b1);
        n_cmp++; if (sync_out !== 1'b1 || err_count !== 2'd0) begin n_err++; $display("FAIL lock_repeat2 sync_out=%b errcnt=%0d want 1/0", sync_out, err_count); end
    endtask

    task automatic test_enable_gap;
        for (int i = 0; i < 3; i++) tick(1'b0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) tick(1'b1);
        n_cmp++; if (phase !== 3'd3 || locked !== 1'b1) begin n_err++; $display("FAIL gap_hold phase=%0d locked=%b want 3/1", phase, locked); end
        n_cmp++; if ({sync_out, err_early, err_missing} !== 3'b0) begin n_err++; $display("FAIL gap_pulses got %b want 000", {sync_out, err_early, err_missing}); end
        en = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (sync_out !== 1'b1 || err_early !== 1'b0 || err_missing !== 1'b0) begin n_err++; $display("FAIL gap_sync sync_out=%b early=%b missing=%b want 1/0/0", sync_out, err_early, err_missing); end
        n_cmp++; if (err_count !== 2'd0 || locked !== 1'b1) begin n_err++; $display("FAIL gap_state errcnt=%0d locked=%b want 0/1", err_count, locked); end
    endtask

    task automatic test_single_miss;
        period(1'b0);
        n_cmp++; if (err_missing !== 1'b1 || sync_out !== 1'b1) begin n_err++; $display("FAIL miss1 missing=%b sync_out=%b want 1/1", err_missing, sync_out); end
        n_cmp++; if (locked !== 1'b1 || err_count !== 2'd1) begin n_err++; $display("FAIL miss1_state locked=%b errcnt=%0d want 1/1", locked, err_count); end
        period(1'b1);
        n_cmp++; if (err_missing !== 1'b0 || sync_out !== 1'b1) begin n_err++; $display("FAIL miss1_recover missing=%b sync_out=%b want 0/1", err_missing, sync_out); end
    endtask

    task automatic test_double_miss;
        period(1'b0);
        n_cmp++; if (err_missing !== 1'b1 || locked !== 1'b1 || err_count !== 2'd2) begin n_err++; $display("FAIL miss2a missing=%b locked=%b errcnt=%0d want 1/1/2", err_missing, locked, err_count); end
        period(1'b0);
        n_cmp++; if (err_missing !== 1'b1 || locked !== 1'b0 || err_count !== 2'd3) begin n_err++; $display("FAIL miss2b missing=%b locked=%b errcnt=%0d want 1/0/3", err_missing, locked, err_count); end
        period(1'b1);
        n_cmp++; if (locked !== 1'b0 || phase !== 3'd0 || err_missing !== 1'b0) begin n_err++; $display("FAIL reacquire locked=%b phase=%0d missing=%b want 0/0/0", locked, phase, err_missing); end
        period(1'b1);
        period(1'b1);
        n_cmp++; if (locked !== 1'b1 || sync_out !== 1'b1) begin n_err++; $display("FAIL relock locked=%b sync_out=%b want 1/1", locked, sync_out); end
    endtask

    task automatic test_early;
        for (int i = 0; i < 3; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (err_early !== 1'b1 || locked !== 1'b0 || phase !== 3'd0) begin n_err++; $display("FAIL early early=%b locked=%b phase=%0d want 1/0/0", err_early, locked, phase); end
        n_cmp++; if (err_count !== 2'd3 || sync_out !== 1'b0) begin n_err++; $display("FAIL early_sat errcnt=%0d sync_out=%b want 3/0", err_count, sync_out); end
        period(1'b1);
        n_cmp++; if (locked !== 1'b0 || err_early !== 1'b0) begin n_err++; $display("FAIL early_acq locked=%b early=%b want 0/0", locked, err_early); end
        period(1'b1);
        n_cmp++; if (locked !== 1'b1 || sync_out !== 1'b1) begin n_err++; $display("FAIL early_relock locked=%b sync_out=%b want 1/1", locked, sync_out); end
    endtask

    task automatic test_saturation_reset;
        for (int i = 0; i < 2; i++) tick(1'b0);
        tick(1'b1);
        n_cmp++; if (err_early !== 1'b1 || err_count !== 2'd3) begin n_err++; $display("FAIL sat early=%b errcnt=%0d want 1/3", err_early, err_count); end
        period(1'b1);
        period(1'b1);
        n_cmp++; if (locked !== 1'b1) begin n_err++; $display("FAIL sat_relock locked=%b want 1", locked); end
        for (int i = 0; i < 3; i++) tick(1'b0);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({sync_out, locked, err_early, err_missing} !== 4'b0) begin n_err++; $display("FAIL async_flags got %b want 0000", {sync_out, locked, err_early, err_missing}); end
        n_cmp++; if (phase !== 3'd0 || err_count !== 2'd0) begin n_err++; $display("FAIL async_cnt phase=%0d errcnt=%0d want 0/0", phase, err_count); end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_enable_gap;
        test_single_miss;
        test_double_miss;
        test_early;
        test_saturation_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/sync_monitor.md
SYNC_MONITOR -- requirements
Module: sync_monitor

Interface
REQ-001 Parameters SHALL be: ARCHITECTURE, default "BEHAVIORAL", implementation select ("BEHAVIORAL" is the only one required now; "VIRTEX5"/"VIRTEX6" are reserved).
REQ-002 Parameter PERIOD SHALL default to 1024; it is the expected sync spacing in enabled cycles, with PERIOD >= 2.
REQ-003 Parameter PHASE_WIDTH SHALL default to 10; it is the phase counter width, with 2^PHASE_WIDTH >= PERIOD.
REQ-004 Parameter LOCK_COUNT SHALL default to 3; it is the number of consecutive on-time syncs needed to lock, with LOCK_COUNT >= 1.
REQ-005 Parameter MAX_MISS SHALL default to 2; it is the number of consecutive missing syncs that drops lock, with MAX_MISS >= 1.
REQ-006 Parameter ERR_WIDTH SHALL default to 8; it is the error counter width.
REQ-007 Ports SHALL be, in order:
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  asynchronous, active-low reset
 en  in  1  clock enable; sync_in is sampled only when en=1
 sync_in  in  1  incoming periodic sync pulse
 sync_out  out  1  regenerated, flywheeled sync pulse
 phase  out  PHASE_WIDTH  position within the current period
 locked  out  1  high while in LOCKED
 err_early  out  1  one-cycle pulse on an early sync while LOCKED
 err_missing  out  1  one-cycle pulse on a missing sync while LOCKED
 err_count  out  ERR_WIDTH  saturating total of err_early plus err_missing events

Function
REQ-008 With en=0, all state, phase and err_count SHALL hold, and sync_out, err_early and err_missing SHALL be 0.
REQ-009 The phase counter SHALL increment once per enabled cycle, wrap from PERIOD-1 to 0, and be forced to 0 on an accepted or restarting sync.
REQ-010 A sync is on-time if sync_in=1 while phase==PERIOD-1; a sync is early if sync_in=1 at any other phase.
REQ-011 A sync is missing if phase==PERIOD-1 with sync_in=0.
REQ-012 The FSM SHALL have the states SEARCH, ACQUIRE and LOCKED, and SHALL reset to SEARCH.
REQ-013 SEARCH: any sync_in sets phase to 0 and good count to 1, then goes to ACQUIRE, or to LOCKED if LOCK_COUNT==1; otherwise phase free-runs.
REQ-014 ACQUIRE, on-time sync: good count increments; on reaching LOCK_COUNT the FSM goes to LOCKED.
REQ-015 ACQUIRE, early sync: phase is set to 0 and good count to 1, and the FSM stays in ACQUIRE.
REQ-016 ACQUIRE, missing sync: the FSM goes to SEARCH; no error pulse is raised outside LOCKED.
REQ-017 LOCKED, on-time sync: the miss count clears.
REQ-018 LOCKED, missing sync: err_missing pulses, the miss count increments, and phase keeps wrapping (flywheel); when the miss count reaches MAX_MISS the FSM goes to SEARCH.
REQ-019 LOCKED, early sync: err_early pulses, phase is set to 0, good count is set to 1, and the FSM goes to ACQUIRE.
REQ-020 sync_out SHALL be registered and pulse for one cycle on the cycle after each phase wrap taken while LOCKED, or while entering LOCKED; latency from an on-time sync_in is 1 cycle.
REQ-021 locked SHALL be registered and equal (state==LOCKED).
REQ-022 err_count SHALL increment on each error pulse and saturate at 2^ERR_WIDTH-1.
REQ-023 The good and miss counters SHALL be wide enough for LOCK_COUNT and MAX_MISS respectively.

Reset
REQ-024 rst=0 SHALL asynchronously force the state to SEARCH, clear phase, good, miss and err_count, and drive every output to 0.
REQ-025 Deassertion of rst SHALL be sampled synchronously; the first enabled cycle after release behaves as SEARCH with phase=0.
REQ-026 Reset asserted mid-lock SHALL drop locked in the same cycle, without waiting for a clock edge.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (SEARCH=0, ACQUIRE=1, LOCKED=2) and the ARCHITECTURE string constants.
REQ-028 The phase counter SHALL be a separate sub-module, sync_phase_counter, with enable, load-zero, wrap at PERIOD-1, and a terminal-count output.

Verification
Test configuration: PERIOD=8, LOCK_COUNT=3, MAX_MISS=2, ERR_WIDTH=2, en=1 unless stated.
REQ-029 Lock: syncs at cycles 10, 18 and 26 -> locked=1 and sync_out=1 at cycle 27; sync_out repeats at 35 and 43 when sync_in continues at 34 and 42.
REQ-030 Single miss: while locked, omit the sync at 34 -> err_missing=1 at 35, sync_out still at 35, locked stays 1, err_count=1.
REQ-031 Double miss: omit the syncs at 34 and 42 -> two err_missing pulses and locked=0 from 43; a sync at 50 re-enters ACQUIRE.
REQ-032 Early sync: while locked, sync_in at phase 3 -> err_early pulse, locked=0 next cycle, phase=0; lock is regained after 2 further on-time syncs.
REQ-033 Enable gap: en=0 for 5 cycles mid-period -> phase holds; the next sync, delayed by 5 cycles, is accepted on-time with no error.
REQ-034 Saturation and reset: 5 error events -> err_count=3; then rst=0 mid-period -> all outputs are 0 immediately, without a clock edge.
